move_scheduler: RTL and testbench

Sequencing controller for the Tetris falling-piece datapath. Turns frame ticks and keyboard keycodes into an ordered stream of single-step board operations: shift left/right, rotate, gravity drop, lock, line-clear and spawn. Issues one operation at a time over a req/ack handshake and reacts to the datapath's collision verdict. Sits between the keyboard/VGA-frame sources and the board/piece datapath, replacing ad-hoc per-clock motion registers with one arbitrated schedule.

---
 rtl/move_scheduler.sv | 236 +++++++++++++++++++++++
 tb/tb_move_scheduler.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/move_scheduler.sv
// move_scheduler: arbitrates frame-driven gravity and keyboard moves into a
// single req/ack stream of board operations (shift, rotate, drop, lock,
// line-clear, spawn) and tracks game-over and the spawn count.
module move_scheduler #(
    parameter int FRAMES_PER_DROP      = 14,
    parameter int FAST_FRAMES_PER_DROP = 2,
    parameter int REPEAT_DELAY         = 10,
    parameter int REPEAT_FRAMES        = 4
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        frame_clk,
    input  logic [7:0]  keycode,
    input  logic        game_en,
    output logic        move_req,
    output logic [2:0]  move_op,
    input  logic        move_ack,
    input  logic        move_blocked,
    output logic        game_over,
    output logic [15:0] pieces_spawned
);

    typedef enum logic [2:0] {
        S_START,
        S_IDLE,
        S_MOVE,
        S_LOCK,
        S_CLEAR,
        S_SPAWN,
        S_OVER
    } state_t;

    localparam logic [2:0] OP_NONE   = 3'd0;
    localparam logic [2:0] OP_LEFT   = 3'd1;
    localparam logic [2:0] OP_RIGHT  = 3'd2;
    localparam logic [2:0] OP_ROTATE = 3'd3;
    localparam logic [2:0] OP_DOWN   = 3'd4;
    localparam logic [2:0] OP_LOCK   = 3'd5;
    localparam logic [2:0] OP_CLEAR  = 3'd6;
    localparam logic [2:0] OP_SPAWN  = 3'd7;

    localparam logic [7:0] KEY_LEFT   = 8'h04;
    localparam logic [7:0] KEY_RIGHT  = 8'h07;
    localparam logic [7:0] KEY_ROTATE = 8'h1A;
    localparam logic [7:0] KEY_SOFT   = 8'h16;

    localparam logic [7:0] GRAV_LAST  = 8'(FRAMES_PER_DROP - 1);
    localparam logic [7:0] FAST_LAST  = 8'(FAST_FRAMES_PER_DROP - 1);
    localparam logic [7:0] REP_LAST   = 8'(REPEAT_DELAY - 1);
    // After the first repeat the hold counter is rewound so that it reaches
    // REP_LAST again every REPEAT_FRAMES ticks (requires REPEAT_FRAMES <= REPEAT_DELAY).
    localparam logic [7:0] REP_RELOAD = 8'(REPEAT_DELAY - REPEAT_FRAMES);

    state_t     state;
    logic [1:0] rst_pipe;
    logic       rst_n;
    logic       fc_meta, fc_sync, fc_prev;
    logic       frame_tick;
    logic [7:0] prev_key;
    logic [7:0] grav_cnt;
    logic [7:0] hold_cnt;
    logic       grav_pend;
    logic       in_pend;
    logic [2:0] in_op;

    logic       key_change, key_press, is_shift, run;
    logic [2:0] key_op;
    logic [7:0] grav_last;
    logic       grav_fire, rep_fire, issue_in, issue_grav, spawn_ok;

    // Reset: asserts immediately, releases synchronously to Clk
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) rst_pipe <= '0;
        else          rst_pipe <= {rst_pipe[0], 1'b1};
    end

    assign rst_n = rst_pipe[1];

    // Bring frame_clk into the Clk domain and keep the previous keycode
    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            fc_meta  <= 1'b0;
            fc_sync  <= 1'b0;
            fc_prev  <= 1'b0;
            prev_key <= '0;
        end else begin
            fc_meta  <= frame_clk;
            fc_sync  <= fc_meta;
            fc_prev  <= fc_sync;
            prev_key <= keycode;
        end
    end

    assign frame_tick = fc_sync & ~fc_prev;

    // Event decode: key presses, repeat/drop firing, issue decisions
    always_comb begin
        key_op = OP_NONE;
        case (keycode)
            KEY_LEFT:   key_op = OP_LEFT;
            KEY_RIGHT:  key_op = OP_RIGHT;
            KEY_ROTATE: key_op = OP_ROTATE;
            default:    key_op = OP_NONE;
        endcase
        key_change = (keycode != prev_key);
        key_press  = key_change && (key_op != OP_NONE);
        is_shift   = (key_op == OP_LEFT) || (key_op == OP_RIGHT);
        run        = game_en && (state != S_START) && (state != S_OVER);
        grav_last  = (keycode == KEY_SOFT) ? FAST_LAST : GRAV_LAST;
        grav_fire  = run && frame_tick && (grav_cnt >= grav_last);
        rep_fire   = run && frame_tick && is_shift && !key_change && (hold_cnt == REP_LAST);
        issue_in   = (state == S_IDLE) && game_en && in_pend;
        issue_grav = (state == S_IDLE) && game_en && !in_pend && grav_pend;
        spawn_ok   = (state == S_SPAWN) && move_ack && !move_blocked;
    end

    // Gravity counter and pending drop; a fresh piece restarts the count
    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            grav_cnt  <= '0;
            grav_pend <= 1'b0;
        end else if (spawn_ok) begin
            grav_cnt  <= '0;
            grav_pend <= 1'b0;
        end else begin
            if (run && frame_tick)
                grav_cnt <= grav_fire ? '0 : grav_cnt + 8'd1;
            if (grav_fire)
                grav_pend <= 1'b1;
            else if (issue_grav)
                grav_pend <= 1'b0;
        end
    end

    // Left/right hold counter for auto-repeat, restarted on any key change
    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n)
            hold_cnt <= '0;
        else if (key_change)
            hold_cnt <= '0;
        else if (run && frame_tick && is_shift)
            hold_cnt <= rep_fire ? REP_RELOAD : hold_cnt + 8'd1;
    end

    // Pending input move; a newer press or repeat overwrites the older op
    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            in_pend <= 1'b0;
            in_op   <= OP_NONE;
        end else if (run && (key_press || rep_fire)) begin
            in_pend <= 1'b1;
            in_op   <= key_op;
        end else if (issue_in) begin
            in_pend <= 1'b0;
        end
    end

    // Operation sequencer with registered request, op, game-over and spawn count
    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_START;
            move_req       <= 1'b0;
            move_op        <= OP_NONE;
            game_over      <= 1'b0;
            pieces_spawned <= '0;
        end else begin
            case (state)
                S_START: begin
                    if (game_en) begin
                        state    <= S_SPAWN;
                        move_req <= 1'b1;
                        move_op  <= OP_SPAWN;
                    end
                end
                S_IDLE: begin
                    if (issue_in) begin
                        state    <= S_MOVE;
                        move_req <= 1'b1;
                        move_op  <= in_op;
                    end else if (issue_grav) begin
                        state    <= S_MOVE;
                        move_req <= 1'b1;
                        move_op  <= OP_DOWN;
                    end
                end
                S_MOVE: begin
                    if (move_ack) begin
                        if ((move_op == OP_DOWN) && move_blocked) begin
                            state   <= S_LOCK;
                            move_op <= OP_LOCK;
                        end else begin
                            state    <= S_IDLE;
                            move_req <= 1'b0;
                            move_op  <= OP_NONE;
                        end
                    end
                end
                S_LOCK: begin
                    if (move_ack) begin
                        state   <= S_CLEAR;
                        move_op <= OP_CLEAR;
                    end
                end
                S_CLEAR: begin
                    if (move_ack) begin
                        state   <= S_SPAWN;
                        move_op <= OP_SPAWN;
                    end
                end
                S_SPAWN: begin
                    if (move_ack) begin
                        move_req <= 1'b0;
                        move_op  <= OP_NONE;
                        if (move_blocked) begin
                            state     <= S_OVER;
                            game_over <= 1'b1;
                        end else begin
                            state          <= S_IDLE;
                            pieces_spawned <= pieces_spawned + 16'd1;
                        end
                    end
                end
                S_OVER: begin
                    move_req <= 1'b0;
                    move_op  <= OP_NONE;
                end
                default: begin
                    state    <= S_START;
                    move_req <= 1'b0;
                    move_op  <= OP_NONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_move_scheduler.sv
// tb_move_scheduler: drives frame pulses, keycodes and pause, acts as the
// datapath (acks after a fixed delay), and compares the issued op stream
// against an event-level model of the scheduling rules.
module tb_move_scheduler;

    localparam int FPD     = 14;
    localparam int FAST    = 2;
    localparam int RD      = 10;
    localparam int RF      = 4;
    localparam int ACK_DLY = 2;
    localparam int SETTLE  = 40;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        frame_clk;
    logic [7:0]  keycode;
    logic        game_en;
    logic        move_req;
    logic [2:0]  move_op;
    logic        move_ack = 1'b0;
    logic        move_blocked = 1'b0;
    logic        game_over;
    logic [15:0] pieces_spawned;

    int n_checks = 0;
    int n_errors = 0;

    logic block_down  = 1'b0;
    logic block_spawn = 1'b0;
    logic spurious    = 1'b0;

    logic [2:0] obs_q[$];
    logic [2:0] exp_q[$];

    // behavioural model state
    int         m_g;
    int         m_h;
    int         m_pieces;
    logic [7:0] m_key;
    bit         m_en;
    bit         m_over;

    logic [7:0] keys [6] = '{8'h00, 8'h04, 8'h07, 8'h1A, 8'h16, 8'h55};
    logic [7:0] tie_keys [3] = '{8'h1A, 8'h16, 8'h00};

    move_scheduler #(
        .FRAMES_PER_DROP      (FPD),
        .FAST_FRAMES_PER_DROP (FAST),
        .REPEAT_DELAY         (RD),
        .REPEAT_FRAMES        (RF)
    ) dut (
        .Clk            (Clk),
        .Reset_n        (Reset_n),
        .frame_clk      (frame_clk),
        .keycode        (keycode),
        .game_en        (game_en),
        .move_req       (move_req),
        .move_op        (move_op),
        .move_ack       (move_ack),
        .move_blocked   (move_blocked),
        .game_over      (game_over),
        .pieces_spawned (pieces_spawned)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    function automatic logic [2:0] key_to_op(input logic [7:0] k);
        case (k)
            8'h04:   return 3'd1;
            8'h07:   return 3'd2;
            8'h1A:   return 3'd3;
            default: return 3'd0;
        endcase
    endfunction

    function automatic bit is_shift_key(input logic [7:0] k);
        return (k == 8'h04) || (k == 8'h07);
    endfunction

    function automatic int drop_period();
        return (m_key == 8'h16) ? FAST : FPD;
    endfunction

    function automatic logic pick_block(input logic [2:0] op);
        case (op)
            3'd4:    return block_down;
            3'd7:    return block_spawn;
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    // datapath stand-in: ack each request ACK_DLY cycles in, check chaining
    int         wait_cnt = 0;
    logic [2:0] held_op  = 3'd0;
    logic [2:0] last_op  = 3'd0;
    logic       last_blk = 1'b0;
    logic       spur_pulse = 1'b0;
    logic       chain;

    always @(negedge Clk) begin
        if (!Reset_n) begin
            move_ack     = 1'b0;
            move_blocked = 1'b0;
            wait_cnt     = 0;
            spur_pulse   = 1'b0;
        end else if (move_ack) begin
            move_ack     = 1'b0;
            move_blocked = 1'b0;
            if (!spur_pulse) begin
                chain = ((last_op == 3'd4) && last_blk) || (last_op == 3'd5) || (last_op == 3'd6);
                chk("chain_req", move_req, chain);
                if (chain) chk("chain_op", move_op, last_op + 3'd1);
            end
            spur_pulse = 1'b0;
            wait_cnt   = 0;
        end else if (move_req) begin
            if (wait_cnt == 0) held_op = move_op;
            else chk("op_hold", move_op, held_op);
            wait_cnt++;
            if (wait_cnt >= ACK_DLY) begin
                last_op      = move_op;
                last_blk     = pick_block(move_op);
                move_ack     = 1'b1;
                move_blocked = last_blk;
                obs_q.push_back(move_op);
            end
        end else if (spurious) begin
            move_ack     = 1'b1;
            move_blocked = 1'($urandom_range(0, 1));
            spur_pulse   = 1'b1;
        end
    end

    // ---------------- model ----------------
    task automatic expect_spawn();
        exp_q.push_back(3'd7);
        if (block_spawn) m_over = 1;
        else begin
            m_pieces = (m_pieces + 1) % 65536;
            m_g = 0;
        end
    endtask

    task automatic expect_op(input logic [2:0] op);
        exp_q.push_back(op);
        if (op == 3'd4 && block_down) begin
            exp_q.push_back(3'd5);
            exp_q.push_back(3'd6);
            expect_spawn();
        end
    endtask

    task automatic model_key(input logic [7:0] k);
        if (k != m_key) begin
            m_h   = 0;
            m_key = k;
            if (m_en && !m_over && key_to_op(k) != 3'd0) expect_op(key_to_op(k));
        end
    endtask

    task automatic model_tick();
        if (m_en && !m_over) begin
            if (is_shift_key(m_key)) begin
                m_h++;
                if (m_h == RD || (m_h > RD && (m_h - RD) % RF == 0))
                    expect_op(key_to_op(m_key));
            end
            if (m_g >= drop_period() - 1) begin
                m_g = 0;
                expect_op(3'd4);
            end else begin
                m_g++;
            end
        end
    endtask

    task automatic model_reset();
        m_g = 0; m_h = 0; m_pieces = 0; m_key = keycode; m_en = game_en; m_over = 0;
    endtask

    // ---------------- stimulus steps ----------------
    task automatic settle();
        repeat (SETTLE) @(negedge Clk);
    endtask

    task automatic check_ops(input string tag);
        int n;
        chk({tag, "_count"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk({tag, "_op"}, obs_q[i], exp_q[i]);
        obs_q.delete();
        exp_q.delete();
        chk({tag, "_pieces"}, pieces_spawned, m_pieces);
        chk({tag, "_over"}, game_over, m_over);
        chk({tag, "_req_idle"}, move_req, 1'b0);
    endtask

    task automatic do_tick(input string tag, input bit tie, input logic [7:0] tie_key);
        @(negedge Clk);
        frame_clk = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
        if (tie) begin
            keycode = tie_key;
            model_key(tie_key);
        end
        model_tick();
        @(negedge Clk);
        frame_clk = 1'b0;
        settle();
        check_ops(tag);
    endtask

    task automatic set_key(input string tag, input logic [7:0] k);
        @(negedge Clk);
        keycode = k;
        model_key(k);
        settle();
        check_ops(tag);
    endtask

    task automatic set_en(input string tag, input logic e);
        @(negedge Clk);
        game_en = e;
        m_en = e;
        settle();
        check_ops(tag);
    endtask

    task automatic tick_until_drop(input string tag);
        bit fires;
        for (int i = 0; i < 40; i++) begin
            fires = (m_g >= drop_period() - 1);
            do_tick(tag, 1'b0, 8'h00);
            if (fires) break;
        end
    endtask

    task automatic tick_until_armed(input string tag);
        for (int i = 0; i < 40; i++) begin
            if (m_g >= drop_period() - 1) break;
            do_tick(tag, 1'b0, 8'h00);
        end
    endtask

    task automatic spurious_step(input string tag);
        @(negedge Clk);
        spurious = 1'b1;
        repeat (8) @(negedge Clk);
        spurious = 1'b0;
        settle();
        check_ops(tag);
    endtask

    task automatic pause_test();
        bit seen;
        tick_until_armed("pause_pre");
        block_down = 1'b1;
        @(negedge Clk);
        frame_clk = 1'b1;
        model_tick();
        repeat (3) @(negedge Clk);
        frame_clk = 1'b0;
        seen = 0;
        for (int w = 0; w < 40 && !seen; w++) begin
            @(negedge Clk);
            seen = move_req && (move_op == 3'd5);
        end
        chk("pause_lock_seen", seen, 1'b1);
        keycode = 8'h07;
        m_key = 8'h07;
        m_h = 0;
        @(negedge Clk);
        game_en = 1'b0;
        m_en = 0;
        settle();
        block_down = 1'b0;
        check_ops("pause_chain");
        @(negedge Clk);
        game_en = 1'b1;
        m_en = 1;
        expect_op(3'd2);
        settle();
        check_ops("resume");
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        Reset_n   = 1'b0;
        frame_clk = 1'b0;
        keycode   = 8'h00;
        game_en   = 1'b1;
        repeat (3) @(negedge Clk);
        chk("rst_req", move_req, 1'b0);
        chk("rst_op", move_op, 3'd0);
        chk("rst_over", game_over, 1'b0);
        chk("rst_pieces", pieces_spawned, 16'd0);
        model_reset();
        Reset_n = 1'b1;
        expect_spawn();
        settle();
        check_ops("first_spawn");

        // plain gravity
        repeat (28) do_tick("gravity", 1'b0, 8'h00);

        // left held: press plus auto-repeat
        set_key("press_left", 8'h04);
        repeat (20) do_tick("hold_left", 1'b0, 8'h00);
        set_key("release_left", 8'h00);

        // rotate press coinciding with a drop, then soft drop
        tick_until_armed("tie_pre");
        do_tick("tie_rotate", 1'b1, 8'h1A);
        set_key("soft_on", 8'h16);
        repeat (7) do_tick("soft_drop", 1'b0, 8'h00);
        set_key("soft_off", 8'h00);

        // blocked drop -> lock, clear, spawn; gravity restarts
        block_down = 1'b1;
        tick_until_drop("lock_chain");
        block_down = 1'b0;
        repeat (15) do_tick("after_lock", 1'b0, 8'h00);

        spurious_step("spurious_idle");
        pause_test();
        set_key("pause_release", 8'h00);

        // randomized mix
        for (int i = 0; i < 250; i++) begin
            block_down = ($urandom_range(0, 5) == 0);
            r = $urandom_range(0, 99);
            if (r < 55)      do_tick("rnd_tick", 1'b0, 8'h00);
            else if (r < 62) do_tick("rnd_tie", 1'b1, tie_keys[$urandom_range(0, 2)]);
            else if (r < 92) set_key("rnd_key", keys[$urandom_range(0, 5)]);
            else             set_en("rnd_en", ~game_en);
        end
        block_down = 1'b0;
        set_en("rnd_end", 1'b1);
        set_key("rnd_release", 8'h00);

        // spawn collision -> game over, everything ignored
        block_down  = 1'b1;
        block_spawn = 1'b1;
        tick_until_drop("to_over");
        block_down  = 1'b0;
        block_spawn = 1'b0;
        for (int i = 0; i < 100; i++) begin
            do_tick("over_tick", 1'b0, 8'h00);
            if (i % 10 == 0) set_key("over_key", keys[(i / 10) % 4]);
        end
        spurious_step("spurious_over");

        // reset recovers
        @(negedge Clk);
        keycode = 8'h00;
        Reset_n = 1'b0;
        @(negedge Clk);
        chk("rst2_over", game_over, 1'b0);
        chk("rst2_req", move_req, 1'b0);
        chk("rst2_pieces", pieces_spawned, 16'd0);
        @(negedge Clk);
        model_reset();
        Reset_n = 1'b1;
        expect_spawn();
        settle();
        check_ops("respawn");
        repeat (14) do_tick("post_reset", 1'b0, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
